// File: rtl/rocket_game_ctl_pkg.sv
// Shared definitions for the rocket game sequencer and the HUD that reads it.
// Contents:
//   game_state_t   - 3-bit state codes presented on game_state
//   PAD_X_*_DEF    - default landing pad bounds (x_pos units)
//   FUEL_MAX_DEF   - fuel units loaded at each ARM
//   LIVES_INIT_DEF - lives at game start
//   sat_inc8 / sat_dec3 - saturating counter helpers for score and lives
package rocket_game_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_PLAY      = 3'd2,
    ST_LAND_OK   = 3'd3,
    ST_CRASH     = 3'd4,
    ST_GAME_OVER = 3'd5
  } game_state_t;

  localparam logic [11:0] PAD_X_MIN_DEF  = 12'd600;
  localparam logic [11:0] PAD_X_MAX_DEF  = 12'd700;
  localparam int unsigned FUEL_MAX_DEF   = 32'd255;
  localparam int unsigned LIVES_INIT_DEF = 32'd3;

  // Score counts up and sticks at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Lives count down and stick at 0.
  function automatic logic [2:0] sat_dec3(input logic [2:0] v);
    if (v == 3'd0) begin
      return v;
    end else begin
      return v - 3'd1;
    end
  endfunction

endpackage

// File: rtl/rocket_game_ctl_fuel_meter.sv
// Fuel meter: a tick counter that advances on every cycle of thrust and a
// fuel register that loses one unit each time the counter wraps.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (fuel=FUEL_MAX, ticks=0)
//   load      - reload fuel to FUEL_MAX and clear the tick counter
//   burn_en   - thrust is being applied this cycle
//   empty     - fuel is zero after this edge (look-ahead, combinational)
//   fuel      - remaining fuel, registered
module rocket_game_ctl_fuel_meter
  import rocket_game_ctl_pkg::*;
#(
  parameter int unsigned FUEL_MAX  = FUEL_MAX_DEF,
  parameter int unsigned FUEL_TICK = 32'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       burn_en,
  output logic       empty,
  output logic [7:0] fuel
);

  localparam int unsigned TICK_W = (FUEL_TICK > 32'd1) ? $clog2(FUEL_TICK) : 32'd1;
  localparam logic [TICK_W-1:0] TICK_LAST =
    (FUEL_TICK > 32'd0) ? TICK_W'(FUEL_TICK - 32'd1) : '0;
  localparam logic [7:0] FUEL_LOAD = 8'(FUEL_MAX);

  logic [TICK_W-1:0] tick_r;
  logic [TICK_W-1:0] tick_next_s;
  logic [7:0]        fuel_r;
  logic [7:0]        fuel_next_s;

  // Next tick/fuel values: load wins, burning stops once the tank is dry.
  always_comb begin
    tick_next_s = tick_r;
    fuel_next_s = fuel_r;
    if (load) begin
      tick_next_s = '0;
      fuel_next_s = FUEL_LOAD;
    end else if (burn_en && (fuel_r != 8'd0)) begin
      if (tick_r == TICK_LAST) begin
        tick_next_s = '0;
        fuel_next_s = fuel_r - 8'd1;
      end else begin
        tick_next_s = tick_r + 1'b1;
        fuel_next_s = fuel_r;
      end
    end else begin
      tick_next_s = tick_r;
      fuel_next_s = fuel_r;
    end
  end

  // Tick counter and fuel register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r <= '0;
      fuel_r <= FUEL_LOAD;
    end else begin
      tick_r <= tick_next_s;
      fuel_r <= fuel_next_s;
    end
  end

  // Look-ahead so the caller can drop thrust on the same edge fuel hits 0.
  assign empty = (fuel_next_s == 8'd0);
  assign fuel  = fuel_r;

endmodule

// File: rtl/rocket_game_ctl.sv
// Game-level sequencer above the rocket motion controller.
// Holds the rocket controller in reset outside PLAY, gates the player's
// buttons through to it, meters fuel, judges landings against the pad,
// keeps lives and score, and sequences round restart and game over.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   start_btn                   - debounced start level (acts on rising edge)
//   up_in, left_in, right_in    - player controls
//   landed, collision, x_pos    - status from the rocket controller
//   up_o, left_o, right_o       - gated controls to the rocket controller
//   rocket_rst                  - reset to the rocket controller
//   game_state, lives, fuel, score, game_over - HUD/status outputs
// All outputs come straight from registers.
module rocket_game_ctl
  import rocket_game_ctl_pkg::*;
#(
  parameter int unsigned ARM_CYCLES   = 32'd16,
  parameter int unsigned PAUSE_CYCLES = 32'd50000000,
  parameter int unsigned FUEL_MAX     = FUEL_MAX_DEF,
  parameter int unsigned FUEL_TICK    = 32'd1000000,
  parameter int unsigned LIVES_INIT   = LIVES_INIT_DEF,
  parameter logic [11:0] PAD_X_MIN    = PAD_X_MIN_DEF,
  parameter logic [11:0] PAD_X_MAX    = PAD_X_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        up_in,
  input  logic        left_in,
  input  logic        right_in,
  input  logic        landed,
  input  logic        collision,
  input  logic [11:0] x_pos,
  output logic        up_o,
  output logic        left_o,
  output logic        right_o,
  output logic        rocket_rst,
  output logic [2:0]  game_state,
  output logic [2:0]  lives,
  output logic [7:0]  fuel,
  output logic [7:0]  score,
  output logic        game_over
);

  // Timer is loaded with N-1 so a timed state is visible for exactly N cycles.
  localparam logic [31:0] ARM_LOAD =
    (ARM_CYCLES > 32'd0) ? 32'(ARM_CYCLES - 32'd1) : 32'd0;
  localparam logic [31:0] PAUSE_LOAD =
    (PAUSE_CYCLES > 32'd0) ? 32'(PAUSE_CYCLES - 32'd1) : 32'd0;
  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);

  game_state_t state_r;
  game_state_t state_next_s;
  logic        start_q_r;
  logic        start_edge_s;
  logic        on_pad_s;
  logic        play_next_s;
  logic        land_entry_s;
  logic        crash_entry_s;
  logic        restart_s;
  logic [31:0] timer_r;
  logic [2:0]  lives_r;
  logic [7:0]  score_r;
  logic        up_o_r;
  logic        left_o_r;
  logic        right_o_r;
  logic        rocket_rst_r;
  logic        game_over_r;
  logic        fuel_load_s;
  logic        fuel_empty_s;
  logic [7:0]  fuel_s;

  assign start_edge_s  = start_btn & ~start_q_r;
  assign on_pad_s      = (x_pos >= PAD_X_MIN) && (x_pos <= PAD_X_MAX);
  assign play_next_s   = (state_next_s == ST_PLAY);
  assign land_entry_s  = (state_r == ST_PLAY) && (state_next_s == ST_LAND_OK);
  assign crash_entry_s = (state_r != ST_CRASH) && (state_next_s == ST_CRASH);
  assign restart_s     = (state_r == ST_GAME_OVER) && (state_next_s == ST_ARM);
  // Reload fuel on every ARM cycle, including the entry edge, so the HUD
  // shows a full tank for the whole arming period.
  assign fuel_load_s   = (state_next_s == ST_ARM);

  // Start button history for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q_r <= 1'b0;
    end else begin
      start_q_r <= start_btn;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. Collision outranks landing, so a simultaneous
  // collision and touchdown is always a crash.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_next_s = ST_ARM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (timer_r == 32'd0) begin
          state_next_s = ST_PLAY;
        end else begin
          state_next_s = ST_ARM;
        end
      end
      ST_PLAY: begin
        if (collision) begin
          state_next_s = ST_CRASH;
        end else if (landed && on_pad_s) begin
          state_next_s = ST_LAND_OK;
        end else if (landed) begin
          state_next_s = ST_CRASH;
        end else begin
          state_next_s = ST_PLAY;
        end
      end
      ST_LAND_OK: begin
        if (timer_r == 32'd0) begin
          state_next_s = ST_ARM;
        end else begin
          state_next_s = ST_LAND_OK;
        end
      end
      ST_CRASH: begin
        if ((timer_r == 32'd0) && (lives_r == 3'd0)) begin
          state_next_s = ST_GAME_OVER;
        end else if (timer_r == 32'd0) begin
          state_next_s = ST_ARM;
        end else begin
          state_next_s = ST_CRASH;
        end
      end
      ST_GAME_OVER: begin
        if (start_edge_s) begin
          state_next_s = ST_ARM;
        end else begin
          state_next_s = ST_GAME_OVER;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Shared down-counter: loaded on entry to a timed state, counts to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= 32'd0;
    end else if (state_next_s != state_r) begin
      case (state_next_s)
        ST_ARM:              timer_r <= ARM_LOAD;
        ST_LAND_OK, ST_CRASH: timer_r <= PAUSE_LOAD;
        default:             timer_r <= 32'd0;
      endcase
    end else if (timer_r != 32'd0) begin
      timer_r <= timer_r - 32'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Lives and score bookkeeping on round outcomes and game restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lives_r <= LIVES_LOAD;
      score_r <= 8'd0;
    end else if (restart_s) begin
      lives_r <= LIVES_LOAD;
      score_r <= 8'd0;
    end else if (land_entry_s) begin
      lives_r <= lives_r;
      score_r <= sat_inc8(score_r);
    end else if (crash_entry_s) begin
      lives_r <= sat_dec3(lives_r);
      score_r <= score_r;
    end else begin
      lives_r <= lives_r;
      score_r <= score_r;
    end
  end

  // Registered outputs decoded from the next state so they line up with
  // game_state; thrust drops on the same edge the tank runs dry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rocket_rst_r <= 1'b1;
      up_o_r       <= 1'b0;
      left_o_r     <= 1'b0;
      right_o_r    <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      rocket_rst_r <= ~play_next_s;
      up_o_r       <= play_next_s & up_in & ~fuel_empty_s;
      left_o_r     <= play_next_s & left_in;
      right_o_r    <= play_next_s & right_in;
      game_over_r  <= (state_next_s == ST_GAME_OVER);
    end
  end

  rocket_game_ctl_fuel_meter #(
    .FUEL_MAX  (FUEL_MAX),
    .FUEL_TICK (FUEL_TICK)
  ) u_fuel_meter (
    .clk     (clk),
    .rst     (rst),
    .load    (fuel_load_s),
    .burn_en (up_o_r),
    .empty   (fuel_empty_s),
    .fuel    (fuel_s)
  );

  assign up_o       = up_o_r;
  assign left_o     = left_o_r;
  assign right_o    = right_o_r;
  assign rocket_rst = rocket_rst_r;
  assign game_state = state_r;
  assign lives      = lives_r;
  assign fuel       = fuel_s;
  assign score      = score_r;
  assign game_over  = game_over_r;

endmodule

// File: tb/tb_rocket_game_ctl.sv
// Bench for rocket_game_ctl with short timing parameters: a vector table for
// the first round, hand-written multi-cycle sequences, then random play.
// Every cycle is also compared against a round-level reference model.
module tb_rocket_game_ctl;

  localparam int ARM_C   = 4;
  localparam int PAUSE_C = 8;
  localparam int TICK_C  = 4;
  localparam int FMAX    = 3;
  localparam int LIV     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn, up_in, left_in, right_in, landed, collision;
  logic [11:0] x_pos;
  logic        up_o, left_o, right_o, rocket_rst, game_over;
  logic [2:0]  game_state, lives;
  logic [7:0]  fuel, score;

  always #5 clk = ~clk;

  rocket_game_ctl #(
    .ARM_CYCLES(ARM_C), .PAUSE_CYCLES(PAUSE_C), .FUEL_MAX(FMAX),
    .FUEL_TICK(TICK_C), .LIVES_INIT(LIV),
    .PAD_X_MIN(12'd600), .PAD_X_MAX(12'd700)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .up_in(up_in),
    .left_in(left_in), .right_in(right_in), .landed(landed),
    .collision(collision), .x_pos(x_pos), .up_o(up_o), .left_o(left_o),
    .right_o(right_o), .rocket_rst(rocket_rst), .game_state(game_state),
    .lives(lives), .fuel(fuel), .score(score), .game_over(game_over)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (round level) ----------------
  // Phases: 0 idle, 1 arm, 2 play, 3 landed, 4 crashed, 5 game over.
  // Fuel is derived from total thrust cycles burnt since the last arm.
  int m_phase, m_age, m_burn, m_lives, m_score;
  bit m_up, m_left, m_right, m_start_prev;

  function automatic int m_fuel();
    return FMAX - (m_burn / TICK_C);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_burn = 0; m_lives = LIV; m_score = 0;
    m_up = 0; m_left = 0; m_right = 0; m_start_prev = 0;
  endtask

  task automatic model_update();
    bit se;
    bit pad;
    int nxt;
    se  = start_btn && !m_start_prev;
    pad = (x_pos >= 12'd600) && (x_pos <= 12'd700);
    m_start_prev = start_btn;
    nxt = m_phase;
    case (m_phase)
      0: if (se) nxt = 1;
      1: if (m_age == ARM_C - 1) nxt = 2;
      2: if (collision) nxt = 4; else if (landed) nxt = pad ? 3 : 4;
      3: if (m_age == PAUSE_C - 1) nxt = 1;
      4: if (m_age == PAUSE_C - 1) nxt = (m_lives == 0) ? 5 : 1;
      5: if (se) nxt = 1;
      default: nxt = 0;
    endcase
    if (m_up && m_fuel() > 0) m_burn++;
    if (nxt != m_phase) begin
      m_age = 0;
      if (nxt == 3) m_score = (m_score < 255) ? m_score + 1 : 255;
      if (nxt == 4) m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      if (m_phase == 5 && nxt == 1) begin m_lives = LIV; m_score = 0; end
    end else begin
      m_age++;
    end
    if (nxt == 1) m_burn = 0;
    m_phase = nxt;
    m_up    = (nxt == 2) && up_in && (m_fuel() != 0);
    m_left  = (nxt == 2) && left_in;
    m_right = (nxt == 2) && right_in;
  endtask

  // One clock: model advances on the edge, DUT is sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_update();
    #1;
    check("model_state", int'(game_state), m_phase);
    check("model_rocket_rst", int'(rocket_rst), int'(m_phase != 2));
    check("model_up_o", int'(up_o), int'(m_up));
    check("model_left_o", int'(left_o), int'(m_left));
    check("model_right_o", int'(right_o), int'(m_right));
    check("model_lives", int'(lives), m_lives);
    check("model_fuel", int'(fuel), m_fuel());
    check("model_score", int'(score), m_score);
    check("model_game_over", int'(game_over), int'(m_phase == 5));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic idle();
    start_btn = 0; up_in = 0; left_in = 0; right_in = 0;
    landed = 0; collision = 0; x_pos = 12'd0;
  endtask

  // ARM entered on the previous edge: three more ARM cycles, then PLAY.
  task automatic to_play();
    run(ARM_C - 1);
    check("arm_hold", int'(game_state), 1);
    step();
    check("play_entry_state", int'(game_state), 2);
    check("play_entry_rr", int'(rocket_rst), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit st, up, lf, rt, ld, co;
    int x;
    int s, rr, u, l, r, lv, f, sc, go;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit st, bit up, bit lf, bit rt, bit ld, bit co,
                              int x, int s, int rr, int u, int l, int r,
                              int lv, int f, int sc, int go);
    vec_t v;
    v.st = st; v.up = up; v.lf = lf; v.rt = rt; v.ld = ld; v.co = co; v.x = x;
    v.s = s; v.rr = rr; v.u = u; v.l = l; v.r = r;
    v.lv = lv; v.f = f; v.sc = sc; v.go = go;
    return v;
  endfunction

  logic [11:0] xs [8];

  initial begin
    // First round: arm, thrust until dry, steer, land on pad, pause, re-arm.
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,0,0,0,   1,1,0,0,0,2,3,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0,0,0,0,0,   2,0,1,0,0,2,3,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0,0,0,0,0,   2,0,1,0,0,2,2,0,0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0,1,0,0,0,0,0,   2,0,1,0,0,2,1,0,0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0,1,1,0,0,0,0,   2,0,1,1,0,2,1,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,                               2,0,0,1,0,2,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,0,                               2,0,0,1,1,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,650,                             3,1,0,0,0,2,0,1,0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,0,0,0,0,0,   3,1,0,0,0,2,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,                               1,1,0,0,0,2,3,1,0));

    xs[0] = 12'd599; xs[1] = 12'd600; xs[2] = 12'd601; xs[3] = 12'd650;
    xs[4] = 12'd699; xs[5] = 12'd700; xs[6] = 12'd701; xs[7] = 12'd0;

    // Reset state
    rst = 1; idle();
    step();
    check("rst_state", int'(game_state), 0);
    check("rst_rocket_rst", int'(rocket_rst), 1);
    check("rst_lives", int'(lives), 2);
    check("rst_fuel", int'(fuel), 3);
    check("rst_score", int'(score), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_up_o", int'(up_o), 0);
    rst = 0;

    foreach (vecs[i]) begin
      start_btn = vecs[i].st; up_in = vecs[i].up; left_in = vecs[i].lf;
      right_in = vecs[i].rt; landed = vecs[i].ld; collision = vecs[i].co;
      x_pos = 12'(vecs[i].x);
      step();
      check($sformatf("vec%0d_state", i), int'(game_state), vecs[i].s);
      check($sformatf("vec%0d_rocket_rst", i), int'(rocket_rst), vecs[i].rr);
      check($sformatf("vec%0d_up_o", i), int'(up_o), vecs[i].u);
      check($sformatf("vec%0d_left_o", i), int'(left_o), vecs[i].l);
      check($sformatf("vec%0d_right_o", i), int'(right_o), vecs[i].r);
      check($sformatf("vec%0d_lives", i), int'(lives), vecs[i].lv);
      check($sformatf("vec%0d_fuel", i), int'(fuel), vecs[i].f);
      check($sformatf("vec%0d_score", i), int'(score), vecs[i].sc);
      check($sformatf("vec%0d_game_over", i), int'(game_over), vecs[i].go);
    end
    idle();

    // Landed together with collision: one crash, one life lost.
    to_play();
    landed = 1; collision = 1; x_pos = 12'd650;
    step();
    check("both_state", int'(game_state), 4);
    check("both_lives", int'(lives), 1);
    idle();
    run(PAUSE_C - 1);
    check("both_lives_hold", int'(lives), 1);
    check("both_pause_state", int'(game_state), 4);
    step();
    check("crash_to_arm", int'(game_state), 1);
    check("crash_rearm_fuel", int'(fuel), 3);

    // Off-pad landing just below the pad: last life lost, then game over.
    to_play();
    landed = 1; x_pos = 12'd599;
    step();
    check("offpad_state", int'(game_state), 4);
    check("offpad_lives", int'(lives), 0);
    idle();
    run(PAUSE_C);
    check("go_state", int'(game_state), 5);
    check("go_flag", int'(game_over), 1);
    check("go_rocket_rst", int'(rocket_rst), 1);
    start_btn = 1;
    step();
    check("restart_state", int'(game_state), 1);
    check("restart_lives", int'(lives), 2);
    check("restart_score", int'(score), 0);

    // Upper pad edge counts as a landing.
    to_play();
    landed = 1; x_pos = 12'd700;
    step();
    check("pad_max_state", int'(game_state), 3);
    check("pad_max_score", int'(score), 1);
    idle();
    run(PAUSE_C);
    check("land_to_arm", int'(game_state), 1);

    // Reset in the middle of play.
    to_play();
    up_in = 1;
    run(2);
    rst = 1;
    step();
    check("midrst_state", int'(game_state), 0);
    check("midrst_rocket_rst", int'(rocket_rst), 1);
    check("midrst_up_o", int'(up_o), 0);
    check("midrst_fuel", int'(fuel), 3);
    check("midrst_score", int'(score), 0);
    rst = 0; idle();

    // Random play against the model.
    for (int c = 0; c < 4000; c++) begin
      start_btn = ($urandom_range(0, 7) == 0) ? ~start_btn : start_btn;
      up_in     = ($urandom_range(0, 3) != 0);
      left_in   = $urandom_range(0, 1) == 1;
      right_in  = $urandom_range(0, 1) == 1;
      landed    = ($urandom_range(0, 11) == 0);
      collision = ($urandom_range(0, 39) == 0);
      xs[7]     = 12'($urandom_range(0, 4095));
      x_pos     = xs[$urandom_range(0, 7)];
      rst       = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
